// File: rtl/axi_llc_pkg.sv
// Shared LLC types: unit encodings, the data-way request payload and a saturating counter helper.
package axi_llc_pkg;

   localparam int unsigned LlcNumUnits = 4;

   typedef enum logic [1:0] {
      WChanUnit = 2'd0,
      RChanUnit = 2'd1,
      EvictUnit = 2'd2,
      RefilUnit = 2'd3
   } cache_unit_e;

   typedef struct packed {
      cache_unit_e cache_unit;
      logic [2:0]  way_ind;
      logic [9:0]  line_addr;
      logic [1:0]  blk_offset;
      logic        we;
      logic [63:0] data;
      logic [7:0]  strb;
   } way_inp_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/axi_llc_way_arb_rr.sv
// Round-robin pick: first requesting unit at or above prio, wrapping to 0.
module axi_llc_way_arb_rr #(
   parameter int unsigned NumUnits = 4,
   parameter int unsigned IdxW     = $clog2(NumUnits)
) (
   input  logic [NumUnits-1:0] req,
   input  logic [IdxW-1:0]     prio,
   output logic [NumUnits-1:0] gnt,
   output logic [IdxW-1:0]     idx,
   output logic                any
);

   logic [IdxW-1:0] cand;

   // Walk the units from prio upward and take the first one that is valid.
   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int i = 0; i < int'(NumUnits); i++) begin
         cand = IdxW'((int'(prio) + i) % int'(NumUnits));
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end else begin
            any = any;
         end
      end
   end

endmodule

// File: rtl/axi_llc_way_arb.sv
// Data-way arbiter: round-robin over the LLC units into one registered output beat.
// Define AXI_LLC_WAY_ARB_STATS_EN to add saturating per-unit grant counters (grant_cnt_o).
module axi_llc_way_arb
   import axi_llc_pkg::*;
#(
   parameter int unsigned NumUnits  = LlcNumUnits,
   parameter type         way_inp_t = logic,
   localparam int unsigned IdxW     = $clog2(NumUnits)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  way_inp_t            req_i [NumUnits],
   input  logic [NumUnits-1:0] req_valid_i,
   output logic [NumUnits-1:0] req_ready_o,
   output way_inp_t            way_inp_o,
   output logic                way_inp_valid_o,
   input  logic                way_inp_ready_i,
   output logic [IdxW-1:0]     grant_idx_o
`ifdef AXI_LLC_WAY_ARB_STATS_EN
   ,
   output logic [NumUnits-1:0][15:0] grant_cnt_o
`endif
);

   logic                out_valid_q;
   way_inp_t            out_q;
   logic [IdxW-1:0]     grant_idx_q;
   logic [IdxW-1:0]     prio_q;
   logic [IdxW-1:0]     prio_next;
   logic [NumUnits-1:0] rr_gnt;
   logic [IdxW-1:0]     rr_idx;
   logic                rr_any;
   logic                load_en;
   logic                grant;

   axi_llc_way_arb_rr #(
      .NumUnits (NumUnits),
      .IdxW     (IdxW)
   ) i_rr (
      .req  (req_valid_i),
      .prio (prio_q),
      .gnt  (rr_gnt),
      .idx  (rr_idx),
      .any  (rr_any)
   );

   // The stage can take a new beat when empty or when the current one drains this cycle.
   assign load_en     = !out_valid_q || way_inp_ready_i;
   assign grant       = load_en && rr_any && !rst_i;
   assign req_ready_o = grant ? rr_gnt : '0;
   assign prio_next   = (rr_idx == IdxW'(NumUnits - 1)) ? '0 : rr_idx + IdxW'(1);

   // Output register and round-robin pointer.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         grant_idx_q <= '0;
         prio_q      <= '0;
      end else if (grant) begin
         out_valid_q <= 1'b1;
         out_q       <= req_i[rr_idx];
         grant_idx_q <= rr_idx;
         prio_q      <= prio_next;
      end else if (way_inp_ready_i) begin
         out_valid_q <= 1'b0;
      end
   end

   assign way_inp_o       = out_q;
   assign way_inp_valid_o = out_valid_q;
   assign grant_idx_o     = grant_idx_q;

`ifdef AXI_LLC_WAY_ARB_STATS_EN
   logic [NumUnits-1:0][15:0] cnt_q;

   // Per-unit grant counters, saturating so long runs never wrap.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         for (int u = 0; u < int'(NumUnits); u++) begin
            if (grant && rr_gnt[u]) begin
               cnt_q[u] <= sat_inc16(cnt_q[u]);
            end
         end
      end
   end

   assign grant_cnt_o = cnt_q;
`endif

endmodule
